// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle.
//   ALU stream : alu_valid/alu_num/alu_data in, alu_stall out
//   Late stream: late_valid/late_num/late_data in, late_ready out
//   Regfile    : rd_we/rd_num/rd_data out (registered)
//   Hazards    : rs_num/rt_num in, rs_pending/rt_pending out
//   Status     : count (FIFO occupancy 0..4), drained
// The arbiter uses modport slave; the pipeline side uses modport master.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_num;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        late_valid;
  logic [4:0]  late_num;
  logic [31:0] late_data;
  logic        late_ready;
  logic        rd_we;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic        rs_pending;
  logic        rt_pending;
  logic [2:0]  count;
  logic        drained;

  modport slave (
    input  alu_valid, alu_num, alu_data, late_valid, late_num, late_data, rs_num, rt_num,
    output alu_stall, late_ready, rd_we, rd_num, rd_data, rs_pending, rt_pending, count, drained
  );

  modport master (
    output alu_valid, alu_num, alu_data, late_valid, late_num, late_data, rs_num, rt_num,
    input  alu_stall, late_ready, rd_we, rd_num, rd_data, rs_pending, rt_pending, count, drained
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter.
// Merges a single-cycle ALU result stream with a late (load / mul-div) stream buffered in a
// 4-entry in-order FIFO. ALU results win by default; a 2-bit starvation counter forces one
// FIFO pop after three consecutive ALU wins while the FIFO is non-empty.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - wb_arbiter_if.slave (ALU/late inputs, registered regfile write, hazard flags,
//          FIFO occupancy and drained status)
module wb_arbiter (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned Depth = 4;

  logic [4:0]  num_q  [Depth];
  logic [31:0] data_q [Depth];

  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  starve_q, starve_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_num_q, rd_num_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic             stall;
  logic             late_ready;
  logic             alu_win;
  logic             push;
  logic             pop;
  logic [1:0]       offs [Depth];
  logic [Depth-1:0] entry_valid;
  logic             rs_hit;
  logic             rt_hit;

  // Issue selection and FIFO bookkeeping
  always_comb begin
    stall      = (starve_q == 2'd3);
    late_ready = (count_q < 3'(Depth)) && !rst;
    alu_win    = bus.alu_valid && (bus.alu_num != 5'd0) && !stall;
    // ALU results to r0 are dropped and leave the slot free for a pop.
    pop        = !alu_win && (count_q != 3'd0);
    // r0 late transfers complete the handshake but are not stored.
    push       = bus.late_valid && late_ready && (bus.late_num != 5'd0);

    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    rd_we_d   = 1'b0;
    rd_num_d  = rd_num_q;
    rd_data_d = rd_data_q;

    if (alu_win) begin
      rd_we_d   = 1'b1;
      rd_num_d  = bus.alu_num;
      rd_data_d = bus.alu_data;
    end else if (pop) begin
      rd_we_d   = 1'b1;
      rd_num_d  = num_q[rd_ptr_q];
      rd_data_d = data_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 2'd1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Counter can never pass 3: at 3 the stall blocks the ALU and forces a pop.
    if (pop || (count_q == 3'd0)) begin
      starve_d = 2'd0;
    end else if (alu_win) begin
      starve_d = starve_q + 2'd1;
    end
  end

  // Hazard detection against queued entries and the write currently on the regfile port
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      offs[i]        = 2'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offs[i]} < count_q);
      if (entry_valid[i] && (num_q[i] == bus.rs_num)) rs_hit = 1'b1;
      if (entry_valid[i] && (num_q[i] == bus.rt_num)) rt_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      starve_q  <= 2'd0;
      rd_we_q   <= 1'b0;
      rd_num_q  <= 5'd0;
      rd_data_q <= 32'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rd_we_q   <= rd_we_d;
      rd_num_q  <= rd_num_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      num_q[wr_ptr_q]  <= bus.late_num;
      data_q[wr_ptr_q] <= bus.late_data;
    end
  end

  assign bus.alu_stall  = stall;
  assign bus.late_ready = late_ready;
  assign bus.rd_we      = rd_we_q;
  assign bus.rd_num     = rd_num_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.drained    = (count_q == 3'd0) && !rd_we_q;
  assign bus.rs_pending = (bus.rs_num != 5'd0) &&
                          (rs_hit || (rd_we_q && (rd_num_q == bus.rs_num)));
  assign bus.rt_pending = (bus.rt_num != 5'd0) &&
                          (rt_hit || (rd_we_q && (rd_num_q == bus.rt_num)));

endmodule
